// File: rtl/insert_sched_ctrl_pkg.sv
// Shared types and width helpers for the insertion scheduler: FSM state encoding,
// derived port widths and the segment-size normalisation rule.
package insert_sched_ctrl_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StPkt  = 1'b1
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned size_width(input int unsigned max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

  // Inserter only handles even segment lengths; odd requests round down, then cap.
  function automatic int unsigned clamp_seg_size(input int unsigned cfg,
                                                 input int unsigned max_bytes);
    int unsigned sz;
    sz = cfg & ~32'd1;
    return (sz > max_bytes) ? max_bytes : sz;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after last_grant, with wrap.
module rr_arbiter
  import insert_sched_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [IDW-1:0]     grant,
  output logic               any_grant
);

  logic [IDW-1:0] idx;

  // Walk the offsets from far to near so the nearest requester is written last and wins.
  always_comb begin
    grant     = '0;
    idx       = '0;
    any_grant = |req;
    for (int unsigned i = NUM_REQ; i >= 1; i--) begin
      idx = IDW'((32'(last_grant) + i) % NUM_REQ);
      if (req[idx]) begin
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/insert_sched_ctrl.sv
// Grants one tenant AXIS requester at a time to the shared inserter and latches that
// tenant's insertion segment for the duration of its packet.
module insert_sched_ctrl
  import insert_sched_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned AXIS_BUS_WIDTH   = 64,
  parameter int unsigned MAX_INSERT_BYTES = 4,
  localparam int unsigned KW    = AXIS_BUS_WIDTH / 8,
  localparam int unsigned SEG_W = size_width(MAX_INSERT_BYTES),
  localparam int unsigned DW    = MAX_INSERT_BYTES * 8,
  localparam int unsigned IDW   = idx_width(NUM_REQ)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_REQ-1:0]            s_tvalid,
  output logic [NUM_REQ-1:0]            s_tready,
  input  logic [NUM_REQ-1:0]            s_tlast,
  input  logic [NUM_REQ*AXIS_BUS_WIDTH-1:0] s_tdata,
  input  logic [NUM_REQ*KW-1:0]         s_tkeep,
  input  logic [NUM_REQ-1:0]            cfg_enable,
  input  logic [NUM_REQ*SEG_W-1:0]      cfg_seg_size,
  input  logic [NUM_REQ*DW-1:0]         cfg_seg_data,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [AXIS_BUS_WIDTH-1:0]     m_tdata,
  output logic [KW-1:0]                 m_tkeep,
  output logic [SEG_W-1:0]              seg_size,
  output logic [DW-1:0]                 seg_data,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   grant_q, last_q, win;
  logic             any_win;
  logic [SEG_W-1:0] seg_size_q;
  logic [DW-1:0]    seg_data_q;
  logic [NUM_REQ-1:0] eligible;
  logic             fire_last;

  assign eligible  = s_tvalid & cfg_enable;
  assign fire_last = m_tvalid & m_tready & m_tlast;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req        (eligible),
    .last_grant (last_q),
    .grant      (win),
    .any_grant  (any_win)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (any_win) state_d = StPkt;
      StPkt:  if (fire_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The selected tenant's stream passes straight through; nothing is buffered here.
  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    m_tkeep  = '0;
    busy     = 1'b0;
    unique case (state_q)
      StPkt: begin
        busy              = 1'b1;
        m_tvalid          = s_tvalid[grant_q];
        m_tlast           = s_tlast[grant_q];
        m_tdata           = s_tdata[grant_q*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
        m_tkeep           = s_tkeep[grant_q*KW +: KW];
        s_tready[grant_q] = m_tready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      grant_q    <= '0;
      last_q     <= IDW'(NUM_REQ - 1);
      seg_size_q <= '0;
      seg_data_q <= '0;
    end else begin
      if (state_q == StIdle && any_win) begin
        grant_q    <= win;
        seg_size_q <= SEG_W'(clamp_seg_size(32'(cfg_seg_size[win*SEG_W +: SEG_W]),
                                            MAX_INSERT_BYTES));
        seg_data_q <= cfg_seg_data[win*DW +: DW];
      end
      if (state_q == StPkt && fire_last) begin
        last_q <= grant_q;
      end
    end
  end

  assign grant_id = grant_q;
  assign seg_size = seg_size_q;
  assign seg_data = seg_data_q;

endmodule

// File: doc/insert_sched_ctrl.md
INSERT_SCHED_CTRL -- requirements
Module: insert_sched_ctrl

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of tenant AXIS requesters (2..8).
REQ-002 SHALL have parameter AXIS_BUS_WIDTH, default 64, shared stream data width.
REQ-003 SHALL have parameter MAX_INSERT_BYTES, default 4, max inserted segment bytes; even.
REQ-004 SHALL have ports: aclk  in  1  clock; aresetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: s_tvalid / s_tready / s_tlast  in/out/in  NUM_REQ  per-requester handshake and last.
REQ-006 SHALL have ports: s_tdata  in  NUM_REQ*AXIS_BUS_WIDTH; s_tkeep  in  NUM_REQ*AXIS_BUS_WIDTH/8; requester i at slice i.
REQ-007 SHALL have ports: cfg_enable  in  NUM_REQ  per-requester admit enable; cfg_seg_size  in  NUM_REQ*clog2(MAX_INSERT_BYTES+1)  per-requester segment bytes; cfg_seg_data  in  NUM_REQ*MAX_INSERT_BYTES*8  per-requester segment contents.
REQ-008 SHALL have ports: m_tvalid / m_tready / m_tlast  out/in/out  1; m_tdata  out  AXIS_BUS_WIDTH; m_tkeep  out  AXIS_BUS_WIDTH/8; toward inserter.
REQ-009 SHALL have ports: seg_size  out  clog2(MAX_INSERT_BYTES+1); seg_data  out  MAX_INSERT_BYTES*8; grant_id  out  clog2(NUM_REQ); busy  out  1.

Function
REQ-010 SHALL implement FSM states IDLE and PKT only.
REQ-011 IDLE: eligible = s_tvalid & cfg_enable; if any eligible, SHALL register grant_id = round-robin winner, latch seg_size/seg_data, go PKT next cycle; else stay IDLE.
REQ-012 Round-robin SHALL search from (last_grant+1) mod NUM_REQ upward with wrap; last_grant resets to NUM_REQ-1 so requester 0 has first priority.
REQ-013 PKT: m_tvalid/m_tdata/m_tkeep/m_tlast SHALL mux combinationally from granted requester; s_tready[grant_id]=m_tready; all other s_tready=0.
REQ-014 In IDLE all s_tready=0 and m_tvalid=0; no beat is consumed during arbitration (1-cycle grant latency).
REQ-015 PKT SHALL return to IDLE on the cycle m_tvalid&m_tready&m_tlast; last_grant<=grant_id on that edge.
REQ-016 Back-to-back: earliest next grant is the cycle after tlast handshake (IDLE one cycle); no bubble-free chaining.
REQ-017 seg_size/seg_data/grant_id SHALL stay constant from grant until the tlast handshake, regardless of cfg_* changes.
REQ-018 Latched seg_size SHALL be cfg value with bit0 cleared, then clamped to MAX_INSERT_BYTES if larger.
REQ-019 cfg_enable deassertion during PKT SHALL NOT abort the packet; it affects only future arbitration.
REQ-020 busy SHALL be 1 exactly in PKT.
REQ-021 A granted requester dropping s_tvalid mid-packet SHALL hold PKT (m_tvalid=0) indefinitely; no timeout.

Reset
REQ-022 On aresetn=0 at a clock edge: state=IDLE, grant_id=0, last_grant=NUM_REQ-1, seg_size=0, seg_data=0, busy=0, m_tvalid=0, all s_tready=0.
REQ-023 Reset mid-packet SHALL abandon the packet immediately; partial beats are not flushed or terminated.

Structure
REQ-024 Shared package SHALL hold FSM state enum, width-derivation helpers, and seg-size clamp function.
REQ-025 Round-robin selection SHALL be a sub-module rr_arbiter (req vector, last_grant in; grant index, any_grant out; combinational).

Verification
REQ-026 Reset, then s_tvalid=4'b1111, all enabled, 1-beat packets, m_tready=1 -> grant order 0,1,2,3,0; one idle cycle between packets.
REQ-027 Requester 2 cfg_seg_size=4 latched; cfg changed to 2 mid-packet of 3 beats -> seg_size=4 all 3 beats; next packet of req 2 shows 2.
REQ-028 cfg_seg_size=3 -> seg_size=2; cfg_seg_size=6 with MAX=4 -> seg_size=4.
REQ-029 Req 1 valid but cfg_enable[1]=0, req 3 valid -> only 3 granted; s_tready[1] stays 0.
REQ-030 m_tready toggled 0/1 every cycle over 5-beat packet -> all 5 beats forwarded in order, tkeep/tlast intact, grant held.
REQ-031 aresetn pulled low on beat 2 of 4 -> next cycle busy=0, s_tready all 0; after release requester 0 wins first.
